mtr_duty_ctrl: RTL and testbench
================================

MTR_DUTY_CTRL -- requirements
Module: mtr_duty_ctrl

Interface
REQ-001: Parameter SLEW_STEP, default 11'd16: maximum change of the duty output per PWM period.
REQ-002: Parameter SAFE_DUTY, default 11'h400: zero-torque (50%) duty used when idle or faulted.
REQ-003: Parameter OVR_LIMIT, default 4'd10: consecutive overcurrent periods that trigger shutdown.
REQ-004: clk  input  1  system clock, all state updates on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: en  input  1  run enable from the balance controller.
REQ-007: duty_req  input  11  unsigned target duty.
REQ-008: PWM_synch  input  1  one-cycle pulse at the start of each PWM period.
REQ-009: ovr_I_blank  input  1  high while overcurrent sensing is blanked around switching edges.
REQ-010: OVR_I  input  1  raw asynchronous overcurrent comparator output.
REQ-011: clr_fault  input  1  fault-clear request, level-sensitive.
REQ-012: duty  output  11  registered duty to the PWM generator.
REQ-013: fault  output  1  registered, high while in FAULT.
REQ-014: at_target  output  1  combinational, high when duty equals the effective target.

Function
REQ-015: States IDLE, RUN, FAULT, held in a registered state variable.
REQ-016: Effective target SHALL be duty_req in RUN and SAFE_DUTY in IDLE and FAULT.
REQ-017: duty SHALL change only on the clock edge where PWM_synch=1, except when entering FAULT.
REQ-018: On a PWM_synch edge with target > duty, duty SHALL become min(duty+SLEW_STEP, target).
REQ-019: On a PWM_synch edge with target < duty, duty SHALL become max(duty-SLEW_STEP, target).
REQ-020: Slew arithmetic SHALL be 12-bit, so duty never wraps past 11'h7FF or below 11'h000.
REQ-021: OVR_I SHALL pass through a two-flop synchronizer before use; 2-cycle latency.
REQ-022: Per-period flag ovr_seen SHALL set on any cycle with synchronized OVR_I=1 and ovr_I_blank=0.
REQ-023: On a PWM_synch edge, ovr_seen SHALL clear and the 4-bit ovr_cnt update.
REQ-024: ovr_cnt SHALL increment if ovr_seen (or a qualifying event in that same cycle) is set; otherwise it SHALL clear to 0.
REQ-025: ovr_cnt SHALL saturate at OVR_LIMIT.
REQ-026: IDLE->RUN when en=1 and fault=0.
REQ-027: RUN->IDLE when en=0; duty then slews toward SAFE_DUTY.
REQ-028: RUN or IDLE->FAULT on the edge where ovr_cnt reaches OVR_LIMIT.
REQ-029: FAULT SHALL take priority over an en change in the same cycle.
REQ-030: On FAULT entry, duty SHALL load SAFE_DUTY immediately without slewing, and fault SHALL assert.
REQ-031: FAULT->IDLE only when clr_fault=1 and en=0; ovr_cnt and ovr_seen clear on that edge.
REQ-032: clr_fault with en=1 SHALL be ignored.
REQ-033: While in FAULT, ovr_cnt SHALL hold and new events SHALL not re-trigger anything.
REQ-034: duty_req changes between PWM_synch pulses SHALL have no effect until the next pulse.

Reset
REQ-035: On rst_n low, regardless of operation in progress: state=IDLE, duty=SAFE_DUTY, fault=0, ovr_cnt=0, ovr_seen=0, synchronizer flops=0.
REQ-036: On rst_n low, at_target SHALL be 1.
REQ-037: Reset release SHALL need no PWM_synch to become operational.

Verification
REQ-038: Ramp up: en=1, duty_req=11'h500, PWM_synch every 2048 cycles -> duty 0x410, 0x420 ... reaches 0x500 after 16 pulses; at_target=1.
REQ-039: Clamp: duty=0x7F8, duty_req=0x7FF -> duty=0x7FF after one pulse with no wrap; symmetric test at 0x005 -> 0x000.
REQ-040: Blanking: OVR_I pulses only while ovr_I_blank=1 for 20 periods -> ovr_cnt stays 0 and fault=0.
REQ-041: Fault: unblanked OVR_I in 10 consecutive periods -> fault=1 and duty=0x400 on the 10th PWM_synch edge.
REQ-042: Non-consecutive: 9 faulty periods, 1 clean period, then 9 faulty periods -> no fault.
REQ-043: Recovery: clr_fault=1 with en=1 -> stays in FAULT; en=0 then clr_fault=1 -> IDLE, fault=0; mid-ramp rst_n pulse -> duty=0x400 asynchronously.

Source files
------------

// File: rtl/mtr_duty_ctrl.sv
// Motor duty controller: slew-limits the PWM duty toward a target, qualifies
// synchronized overcurrent events per PWM period and latches a shutdown fault.
module mtr_duty_ctrl #(
  parameter logic [10:0] SLEW_STEP = 11'd16,
  parameter logic [10:0] SAFE_DUTY = 11'h400,
  parameter logic [3:0]  OVR_LIMIT = 4'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [10:0] duty_req,
  input  logic        PWM_synch,
  input  logic        ovr_I_blank,
  input  logic        OVR_I,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        fault,
  output logic        at_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state, next_state;

  logic        ovr_meta, ovr_sync;
  logic        ovr_seen;
  logic [3:0]  ovr_cnt;
  logic [3:0]  cnt_inc;
  logic        ovr_qual;
  logic        period_hit;
  logic        trip;

  logic [10:0] target;
  logic [11:0] duty_up, duty_dn;
  logic [10:0] duty_slewed;

  // Overcurrent qualification and trip detection.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ovr_qual   = 1'b0;
    period_hit = 1'b0;
    cnt_inc    = ovr_cnt;
    trip       = 1'b0;

    ovr_qual   = ovr_sync & ~ovr_I_blank;
    // A qualifying event on the PWM_synch cycle itself still counts for the
    // period that is closing.
    period_hit = ovr_seen | ovr_qual;
    cnt_inc    = (ovr_cnt >= OVR_LIMIT) ? OVR_LIMIT : ovr_cnt + 4'd1;
    trip       = PWM_synch && (state != FAULT) && period_hit && (cnt_inc == OVR_LIMIT);
  end

  // Next-state logic; a trip outranks any en change in the same cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (trip)    next_state = FAULT;
        else if (en) next_state = RUN;
      end
      RUN: begin
        if (trip)     next_state = FAULT;
        else if (!en) next_state = IDLE;
      end
      FAULT: begin
        if (clr_fault && !en) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Slew toward the effective target in 12 bits; bit 11 of the subtraction
  // is the borrow, so neither direction can wrap past the 11-bit range.
  always_comb begin
    target      = (state == RUN) ? duty_req : SAFE_DUTY;
    duty_up     = {1'b0, duty} + {1'b0, SLEW_STEP};
    duty_dn     = {1'b0, duty} - {1'b0, SLEW_STEP};
    duty_slewed = duty;

    if (target > duty) begin
      duty_slewed = (duty_up > {1'b0, target}) ? target : duty_up[10:0];
    end else if (target < duty) begin
      duty_slewed = (duty_dn[11] || (duty_dn[10:0] < target)) ? target : duty_dn[10:0];
    end

    at_target = (duty == target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_meta <= 1'b0;
      ovr_sync <= 1'b0;
    end else begin
      ovr_meta <= OVR_I;
      ovr_sync <= ovr_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= SAFE_DUTY;
      fault    <= 1'b0;
      ovr_cnt  <= 4'd0;
      ovr_seen <= 1'b0;
    end else begin
      fault <= (next_state == FAULT);

      if (trip) begin
        // Shutdown bypasses the slew limiter.
        duty     <= SAFE_DUTY;
        ovr_cnt  <= OVR_LIMIT;
        ovr_seen <= 1'b0;
      end else if (state == FAULT) begin
        // Counter holds and events are ignored until a valid clear.
        if (next_state == IDLE) begin
          ovr_cnt  <= 4'd0;
          ovr_seen <= 1'b0;
        end
      end else if (PWM_synch) begin
        duty     <= duty_slewed;
        ovr_seen <= 1'b0;
        ovr_cnt  <= period_hit ? cnt_inc : 4'd0;
      end else if (ovr_qual) begin
        ovr_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Scoreboard bench for mtr_duty_ctrl: directed periods push hand-computed
// expectations; a monitor pops and compares at each check point.
module tb_mtr_duty_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [10:0] duty_req;
  logic        PWM_synch;
  logic        ovr_I_blank;
  logic        OVR_I;
  logic        clr_fault;
  logic [10:0] duty;
  logic        fault;
  logic        at_target;

  mtr_duty_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .duty_req   (duty_req),
    .PWM_synch  (PWM_synch),
    .ovr_I_blank(ovr_I_blank),
    .OVR_I      (OVR_I),
    .clr_fault  (clr_fault),
    .duty       (duty),
    .fault      (fault),
    .at_target  (at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] duty;
    logic        fault;
    logic        at_target;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  event check_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_exp(input string name, input logic [10:0] d, input logic f,
                          input logic a, input logic [3:0] c);
    exp_t e;
    e.name = name; e.duty = d; e.fault = f; e.at_target = a; e.cnt = c;
    sb_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    n_cmp++;
    if (duty !== e.duty || fault !== e.fault || at_target !== e.at_target ||
        dut.ovr_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s: got duty=%h fault=%b at_target=%b cnt=%0d, want duty=%h fault=%b at_target=%b cnt=%0d",
               e.name, duty, fault, at_target, dut.ovr_cnt, e.duty, e.fault, e.at_target, e.cnt);
    end
  endtask

  // Monitor: compares DUT outputs 1 ns after each check point.
  initial begin
    exp_t e;
    forever begin
      @(check_ev);
      #1;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got an output with no expectation queued, want one queued");
      end else begin
        e = sb_q.pop_front();
        check(e);
      end
    end
  end

  // One PWM period of len cycles; optional OVR_I pulse early in the period.
  task automatic run_period(input int len, input bit ovr, input bit chk);
    for (int i = 0; i < len - 1; i++) begin
      @(negedge clk);
      PWM_synch = 1'b0;
      OVR_I     = ovr && (i == 1);
    end
    @(negedge clk);
    OVR_I     = 1'b0;
    PWM_synch = 1'b1;
    @(posedge clk);
    if (chk) -> check_ev;
    @(negedge clk);
    PWM_synch = 1'b0;
  endtask

  task automatic probe();
    -> check_ev;
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, want completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; duty_req = 11'h000; PWM_synch = 1'b0;
    ovr_I_blank = 1'b0; OVR_I = 1'b0; clr_fault = 1'b0;

    repeat (3) @(negedge clk);
    push_exp("reset_state", 11'h400, 1'b0, 1'b1, 4'd0);
    probe();
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp 0x400 -> 0x500 with long PWM periods.
    en = 1'b1; duty_req = 11'h500;
    for (int k = 1; k <= 16; k++) begin
      push_exp($sformatf("ramp_%0d", k), 11'h400 + 11'(16 * k), 1'b0, k == 16, 4'd0);
      run_period(2048, 1'b0, 1'b1);
    end

    // Upper clamp.
    duty_req = 11'h7F8;
    for (int k = 1; k <= 48; k++) begin
      if (k == 48) push_exp("reach_7f8", 11'h7F8, 1'b0, 1'b1, 4'd0);
      run_period(8, 1'b0, k == 48);
    end
    duty_req = 11'h7FF;
    push_exp("clamp_7ff", 11'h7FF, 1'b0, 1'b1, 4'd0);
    run_period(8, 1'b0, 1'b1);

    // Lower clamp.
    duty_req = 11'h005;
    for (int k = 1; k <= 128; k++) begin
      if (k == 127) push_exp("down_00f", 11'h00F, 1'b0, 1'b0, 4'd0);
      if (k == 128) push_exp("clamp_005", 11'h005, 1'b0, 1'b1, 4'd0);
      run_period(8, 1'b0, k >= 127);
    end
    duty_req = 11'h000;
    push_exp("clamp_000", 11'h000, 1'b0, 1'b1, 4'd0);
    run_period(8, 1'b0, 1'b1);

    // Blanked overcurrent pulses never count.
    ovr_I_blank = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 10 || k == 20) push_exp($sformatf("blank_%0d", k), 11'h000, 1'b0, 1'b1, 4'd0);
      run_period(8, 1'b1, k == 10 || k == 20);
    end
    repeat (4) @(negedge clk);
    ovr_I_blank = 1'b0;

    // Ten consecutive faulty periods trip on the tenth edge.
    duty_req = 11'h100;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1)  push_exp("fault_p1", 11'h010, 1'b0, 1'b0, 4'd1);
      if (k == 9)  push_exp("fault_p9", 11'h090, 1'b0, 1'b0, 4'd9);
      if (k == 10) push_exp("fault_trip", 11'h400, 1'b1, 1'b1, 4'd10);
      run_period(8, 1'b1, k == 1 || k >= 9);
    end
    push_exp("fault_hold", 11'h400, 1'b1, 1'b1, 4'd10);
    run_period(8, 1'b1, 1'b1);

    // Clear with en=1 is ignored; clear with en=0 returns to IDLE.
    clr_fault = 1'b1;
    push_exp("clr_with_en", 11'h400, 1'b1, 1'b1, 4'd10);
    run_period(8, 1'b0, 1'b1);
    en = 1'b0;
    @(negedge clk);
    clr_fault = 1'b0;
    push_exp("clr_to_idle", 11'h400, 1'b0, 1'b1, 4'd0);
    probe();

    // Nine faulty, one clean, nine faulty: no trip.
    en = 1'b1; duty_req = 11'h400;
    for (int k = 1; k <= 19; k++) begin
      if (k == 9)  push_exp("nc_p9", 11'h400, 1'b0, 1'b1, 4'd9);
      if (k == 10) push_exp("nc_clean", 11'h400, 1'b0, 1'b1, 4'd0);
      if (k == 19) push_exp("nc_p19", 11'h400, 1'b0, 1'b1, 4'd9);
      run_period(8, k != 10, k == 9 || k == 10 || k == 19);
    end

    // Mid-ramp asynchronous reset.
    duty_req = 11'h500;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) push_exp("midramp", 11'h430, 1'b0, 1'b0, 4'd0);
      run_period(8, 1'b0, k == 3);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    push_exp("async_reset", 11'h400, 1'b0, 1'b1, 4'd0);
    probe();
    @(negedge clk);
    rst_n = 1'b1;

    // Operational straight after reset; en drop slews back to safe duty.
    push_exp("post_reset_run", 11'h410, 1'b0, 1'b0, 4'd0);
    run_period(8, 1'b0, 1'b1);
    en = 1'b0;
    push_exp("run_to_idle", 11'h400, 1'b0, 1'b1, 4'd0);
    run_period(8, 1'b0, 1'b1);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d expectations left, want 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
